cache_set_assoc_wb: RTL and testbench
=====================================

Name: cache_set_assoc_wb

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache. It is the successor to the direct-mapped cache: way count is configurable, replacement is LRU, dirty lines are written back, and both sides use explicit handshakes. It sits between the CPU load/store port and a word-serial block memory (delayed BRAM model). Hit and miss performance counters are included.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 10, word address width
INDEX_WIDTH, 4, set index bits; NUM_SETS = 2^INDEX_WIDTH
BLOCK_OFFSET_WIDTH, 3, word-in-line bits; BLOCK_SIZE = 2^BLOCK_OFFSET_WIDTH words
WAYS, 2, associativity; legal values 1, 2, 4; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-BLOCK_OFFSET_WIDTH (must be >= 1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  cache can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  store data
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_WIDTH  load data; for a store, the stored word
mem_req  out  1  burst active; held high for the whole burst
mem_we  out  1  1 = write-back burst, 0 = refill burst
mem_addr  out  ADDR_WIDTH  line base address (offset bits = 0); stable during the burst
mem_wdata  out  DATA_WIDTH  current write-back beat word
mem_rdata  in  DATA_WIDTH  refill beat word, valid when mem_valid=1
mem_valid  in  1  beat strobe: accepts a write beat or delivers a read beat
hit_cnt  out  32  number of hits, wraps
miss_cnt  out  32  number of misses, wraps

Behaviour:
- Address split: tag = [ADDR_WIDTH-1 : INDEX_WIDTH+BLOCK_OFFSET_WIDTH], index = next INDEX_WIDTH bits, offset = low BLOCK_OFFSET_WIDTH bits.
- Per line storage: valid, dirty, tag, BLOCK_SIZE words. Per set: one log2(WAYS)-bit age per way (0 = MRU).
- Reset (asynchronous): all valid and dirty bits cleared; ages set to the way number; FSM goes to IDLE. req_ready=1, resp_valid=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. Reset mid-burst drops mem_req immediately and discards the partial line.
- FSM states: IDLE, LOOKUP, WB, REFILL, RESP.
- IDLE: on req_valid & req_ready, register we/addr/wdata, then go to LOOKUP. The CPU may change req_* afterwards.
- LOOKUP, hit (valid & tag match in exactly one way):
  - Load returns the word; store writes the word and sets dirty.
  - LRU is updated; hit_cnt increments.
  - resp_valid pulses in the next cycle (response 2 cycles after accept), and the FSM returns to IDLE in that same cycle.
- LOOKUP, miss: miss_cnt increments.
  - Victim = lowest-numbered invalid way; otherwise the way with age WAYS-1.
  - Victim valid & dirty → WB; otherwise → REFILL.
- WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}. Beat k drives victim word k on mem_wdata; k advances on mem_valid. After beat BLOCK_SIZE-1 is accepted, mem_req goes low for at least 1 cycle, then → REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = {req tag, index, 0}. Beat k writes mem_rdata into word k on mem_valid. After the last beat:
  - line installed with valid=1, tag set, dirty = req_we;
  - for a store, the store word is merged at the offset;
  - LRU updated; → RESP.
- RESP: resp_valid=1 for 1 cycle with the word at the offset; → IDLE.
- LRU update on access to way w with old age a: ways with age < a increment, way w becomes 0. Ages remain a permutation of 0..WAYS-1.
- mem_valid outside WB/REFILL is ignored. Arbitrary gaps between beats are legal; all mem_* outputs hold stable while waiting.
- WAYS=1 degenerates to direct-mapped write-back: age logic is removed and the victim is always way 0.

Test Plan:
(Default parameters: TAG_WIDTH=3.)
1. Cold load 0x008, memory returns 0x100..0x107 → one refill burst at mem_addr 0x008, no WB, resp_rdata=0x100, miss_cnt=1. Then load 0x00C → resp_rdata=0x104 exactly 2 cycles after accept, no mem_req, hit_cnt=1.
2. Store 0x00A data 0xDEADBEEF (hit), then load 0x00A → resp_rdata 0xDEADBEEF, hit_cnt=3, no memory traffic.
3. Load 0x088 (index 1, fills way 1, no WB), load 0x008 (hit), load 0x108 → clean way 1 evicted with no WB. Then load 0x088 → dirty way 0 written back: 8 beats at mem_addr 0x008, beat 2 = 0xDEADBEEF, beat 0 = 0x100; refill follows at mem_addr 0x088.
4. Random 0-5 cycle mem_valid gaps over 200 random accesses vs a reference memory model → all resp_rdata match; req_ready=0 and mem_addr stable throughout each burst.
5. rstn pulsed low after refill beat 3 → mem_req=0 asynchronously, counters=0; next load of 0x008 misses and refills.
6. WAYS=1 build: alternate loads 0x008/0x088 ×4 → 8 misses, 0 hits, each refill preceded by no WB.

Source files
------------

// File: rtl/cache_set_assoc_wb.sv
// cache_set_assoc_wb: N-way set-associative write-back, write-allocate cache with LRU
// replacement, word-serial burst memory port and hit/miss counters.
module cache_set_assoc_wb #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter int INDEX_WIDTH        = 4,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int WAYS               = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int TW = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH;
  localparam int NS = 1 << INDEX_WIDTH;
  localparam int BS = 1 << BLOCK_OFFSET_WIDTH;
  localparam int AW = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;
  state_t state, state_nx;
  logic                          r_we, gap, resp_q, hit, found_inv, last, upd;
  logic [ADDR_WIDTH-1:0]         r_addr;
  logic [DATA_WIDTH-1:0]         r_wdata, rword;
  logic [TW-1:0]                 r_tag;
  logic [INDEX_WIDTH-1:0]        idx;
  logic [BLOCK_OFFSET_WIDTH-1:0] off, beat;
  logic [AW-1:0]                 hit_way, inv_way, old_way, vic, vic_q, acc_way, acc_age;
  logic                          vld   [WAYS][NS];
  logic                          drt   [WAYS][NS];
  logic [TW-1:0]                 tag_a [WAYS][NS];
  logic [AW-1:0]                 age   [NS][WAYS];
  logic [DATA_WIDTH-1:0]         data  [WAYS][NS][BS];
  assign r_tag   = r_addr[ADDR_WIDTH-1 -: TW];
  assign idx     = r_addr[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
  assign off     = r_addr[BLOCK_OFFSET_WIDTH-1:0];
  assign last    = &beat;
  assign acc_way = state == LOOKUP ? hit_way : vic_q;
  assign acc_age = age[idx][acc_way];
  assign upd     = (state == LOOKUP && hit) || (state == REFILL && mem_valid && last);
  // Word returned after a refill: the beat arriving now, or one already installed.
  assign rword   = beat == off ? (r_we ? r_wdata : mem_rdata) : data[vic_q][idx][off];
  // Descending scan so the lowest-numbered invalid way wins the victim choice.
  always_comb begin
    hit = 1'b0;
    found_inv = 1'b0;
    hit_way = '0;
    inv_way = '0;
    old_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (vld[w][idx] && tag_a[w][idx] == r_tag) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
      if (age[idx][w] == AW'(WAYS-1)) old_way = AW'(w);
      if (!vld[w][idx]) begin
        found_inv = 1'b1;
        inv_way = AW'(w);
      end
    end
    vic = found_inv ? inv_way : old_way;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? LOOKUP : IDLE;
      LOOKUP:  state_nx = hit ? IDLE : (vld[vic][idx] && drt[vic][idx]) ? WB : REFILL;
      WB:      state_nx = gap ? REFILL : WB;
      REFILL:  state_nx = (mem_valid && last) ? RESP : REFILL;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = resp_q || state == RESP;
    mem_req    = (state == WB && !gap) || state == REFILL;
    mem_we     = state == WB && !gap;
    mem_addr   = state == WB     ? {tag_a[vic_q][idx], idx, {BLOCK_OFFSET_WIDTH{1'b0}}} :
                 state == REFILL ? {r_tag, idx, {BLOCK_OFFSET_WIDTH{1'b0}}} : '0;
    mem_wdata  = mem_we ? data[vic_q][idx][beat] : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      vic_q      <= '0;
      beat       <= '0;
      gap        <= 1'b0;
      resp_q     <= 1'b0;
      resp_rdata <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < NS; s++) begin
          vld[w][s]   <= 1'b0;
          drt[w][s]   <= 1'b0;
          tag_a[w][s] <= '0;
          age[s][w]   <= AW'(w);
        end
    end else begin
      resp_q <= state == LOOKUP && hit;
      if (state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (state == LOOKUP) begin
        vic_q <= vic;
        gap   <= 1'b0;
        if (hit) begin
          hit_cnt    <= hit_cnt + 32'd1;
          resp_rdata <= r_we ? r_wdata : data[hit_way][idx][off];
          if (r_we) drt[hit_way][idx] <= 1'b1;
        end else miss_cnt <= miss_cnt + 32'd1;
      end
      if (mem_req && mem_valid) begin
        beat <= beat + 1'b1;
        if (last) gap <= 1'b1;
      end
      if (state == REFILL && mem_valid && last) begin
        vld[vic_q][idx]   <= 1'b1;
        drt[vic_q][idx]   <= r_we;
        tag_a[vic_q][idx] <= r_tag;
        resp_rdata        <= rword;
      end
      if (upd)
        for (int w = 0; w < WAYS; w++)
          age[idx][w] <= AW'(w) == acc_way ? '0 :
                         age[idx][w] < acc_age ? age[idx][w] + 1'b1 : age[idx][w];
    end
  end
  // Line data carries no reset; validity is tracked by vld alone.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && r_we) data[hit_way][idx][off] <= r_wdata;
    if (state == REFILL && mem_valid) data[vic_q][idx][beat] <= (r_we && beat == off) ? r_wdata : mem_rdata;
  end
endmodule

// File: tb/tb_cache_set_assoc_wb.sv
// tb_cache_set_assoc_wb: directed vector table plus reset and random sequences for a
// 2-way instance, and a direct-mapped (WAYS=1) instance, each behind a gapped memory model.
module tb_cache_set_assoc_wb;
  localparam int DW = 32, AW = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;
  logic          req_valid [2], req_we [2], req_ready [2], resp_valid [2];
  logic          mem_req [2], mem_we [2], mem_valid [2];
  logic [AW-1:0] req_addr [2], mem_addr [2];
  logic [DW-1:0] req_wdata [2], resp_rdata [2], mem_wdata [2], mem_rdata [2];
  logic [31:0]   hit_cnt [2], miss_cnt [2];
  logic [DW-1:0] mem [2][1024];
  logic [DW-1:0] refm [1024];
  logic [DW-1:0] wb_log [2][8];
  logic [AW-1:0] wb_addr [2], rf_addr [2];
  int wb_cnt [2], rf_cnt [2], stab_err [2], rbeat [2];
  int gmax, nvec, nerr;

  cache_set_assoc_wb #(.WAYS(2)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .mem_req(mem_req[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_valid(mem_valid[0]), .hit_cnt(hit_cnt[0]), .miss_cnt(miss_cnt[0]));
  cache_set_assoc_wb #(.WAYS(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .mem_req(mem_req[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_valid(mem_valid[1]), .hit_cnt(hit_cnt[1]), .miss_cnt(miss_cnt[1]));

  // Burst memory model: random gaps before every beat, logs bursts and checks stability.
  for (genvar g = 0; g < 2; g++) begin : rsp
    initial begin
      int gap;
      logic prev;
      logic [AW-1:0] base;
      rbeat[g] = 0; gap = 0; prev = 1'b0; base = '0;
      wb_cnt[g] = 0; rf_cnt[g] = 0; stab_err[g] = 0;
      wb_addr[g] = '0; rf_addr[g] = '0;
      mem_valid[g] = 1'b0; mem_rdata[g] = '0;
      forever begin
        @(posedge clk); #1;
        mem_valid[g] = 1'b0;
        if (mem_req[g] !== 1'b1) begin
          rbeat[g] = 0;
          prev = 1'b0;
        end else begin
          if (!prev) begin
            prev = 1'b1;
            base = mem_addr[g];
            gap = int'($urandom_range(0, gmax));
            if (mem_we[g]) begin wb_cnt[g]++; wb_addr[g] = base; end
            else begin rf_cnt[g]++; rf_addr[g] = base; end
          end
          if (mem_addr[g] !== base || req_ready[g] !== 1'b0) stab_err[g]++;
          if (gap > 0) gap--;
          else begin
            mem_valid[g] = 1'b1;
            if (mem_we[g]) begin
              mem[g][int'(base) + rbeat[g]] = mem_wdata[g];
              wb_log[g][rbeat[g]] = mem_wdata[g];
            end else mem_rdata[g] = mem[g][int'(base) + rbeat[g]];
            rbeat[g] = (rbeat[g] + 1) % 8;
            gap = int'($urandom_range(0, gmax));
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic access(input int d, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
    int n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd;
    @(negedge clk);
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = AW'($urandom); req_wdata[d] = $urandom;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
    rd = resp_rdata[d];
    if (lat >= 2000) begin
      nvec++; nerr++;
      $display("FAIL resp_timeout dut%0d addr %h: no response within %0d cycles", d, a, lat);
    end
  endtask

  typedef struct {
    logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata, rdata;
    int lat, hits, misses, wbs, rfs; logic [AW-1:0] rfa;
  } vec_t;
  vec_t tbl [8];

  initial begin
    logic [DW-1:0] rd, exp_d;
    logic [AW-1:0] a;
    logic we;
    int lat, n, rf0;
    nvec = 0; nerr = 0; gmax = 3;
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = DW'(32'hF8 + i);
      mem[1][i] = DW'(32'hF8 + i);
      refm[i]   = DW'(32'hF8 + i);
    end
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    tbl[0] = '{1'b0, 10'h008, 32'h0,        32'h100,      0, 0, 1, 0, 1, 10'h008};
    tbl[1] = '{1'b0, 10'h00C, 32'h0,        32'h104,      2, 1, 1, 0, 1, 10'h008};
    tbl[2] = '{1'b1, 10'h00A, 32'hDEADBEEF, 32'hDEADBEEF, 2, 2, 1, 0, 1, 10'h008};
    tbl[3] = '{1'b0, 10'h00A, 32'h0,        32'hDEADBEEF, 2, 3, 1, 0, 1, 10'h008};
    tbl[4] = '{1'b0, 10'h088, 32'h0,        32'h180,      0, 3, 2, 0, 2, 10'h088};
    tbl[5] = '{1'b0, 10'h008, 32'h0,        32'h100,      2, 4, 2, 0, 2, 10'h088};
    tbl[6] = '{1'b0, 10'h108, 32'h0,        32'h200,      0, 4, 3, 0, 3, 10'h108};
    tbl[7] = '{1'b0, 10'h088, 32'h0,        32'h180,      0, 4, 4, 1, 4, 10'h088};
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst resp_rdata", resp_rdata[0], 32'd0);
    chk("rst mem_req", 32'(mem_req[0]), 32'd0);
    chk("rst mem_addr", 32'(mem_addr[0]), 32'd0);
    chk("rst mem_wdata", mem_wdata[0], 32'd0);
    chk("rst hit_cnt", hit_cnt[0], 32'd0);
    chk("rst miss_cnt", miss_cnt[0], 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      access(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
      if (tbl[i].we) refm[tbl[i].addr] = tbl[i].wdata;
      chk($sformatf("v%0d rdata", i), rd, tbl[i].rdata);
      if (tbl[i].lat != 0) chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d hit_cnt", i), hit_cnt[0], 32'(tbl[i].hits));
      chk($sformatf("v%0d miss_cnt", i), miss_cnt[0], 32'(tbl[i].misses));
      chk($sformatf("v%0d wb_bursts", i), 32'(wb_cnt[0]), 32'(tbl[i].wbs));
      chk($sformatf("v%0d rf_bursts", i), 32'(rf_cnt[0]), 32'(tbl[i].rfs));
      chk($sformatf("v%0d rf_addr", i), 32'(rf_addr[0]), 32'(tbl[i].rfa));
    end
    chk("wb addr", 32'(wb_addr[0]), 32'h008);
    chk("wb beat0", wb_log[0][0], 32'h100);
    chk("wb beat1", wb_log[0][1], 32'h101);
    chk("wb beat2", wb_log[0][2], 32'hDEADBEEF);
    chk("wb beat7", wb_log[0][7], 32'h107);
    chk("mem 00A after wb", mem[0][10'h00A], 32'hDEADBEEF);

    gmax = 5;
    for (int i = 0; i < 200; i++) begin
      a = {3'($urandom), 4'(1 + $urandom_range(0, 1)), 3'($urandom)};
      we = ($urandom_range(0, 2) == 0);
      exp_d = we ? $urandom : refm[a];
      access(0, we, a, exp_d, rd, lat);
      if (we) refm[a] = exp_d;
      chk($sformatf("rand%0d %s %h", i, we ? "st" : "ld", a), rd, exp_d);
    end
    chk("burst stability dut0", 32'(stab_err[0]), 32'd0);

    n = 0;
    while (req_ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h018;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!(mem_req[0] === 1'b1 && mem_we[0] === 1'b0 && rbeat[0] == 4) && n < 500) begin @(negedge clk); n++; end
    chk("reached refill beat 3", 32'(n < 500), 32'd1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async rst mem_req", 32'(mem_req[0]), 32'd0);
    chk("async rst hit_cnt", hit_cnt[0], 32'd0);
    chk("async rst miss_cnt", miss_cnt[0], 32'd0);
    chk("async rst req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    rf0 = rf_cnt[0];
    exp_d = mem[0][10'h008];
    access(0, 1'b0, 10'h008, '0, rd, lat);
    chk("post-rst rdata", rd, exp_d);
    chk("post-rst miss_cnt", miss_cnt[0], 32'd1);
    chk("post-rst hit_cnt", hit_cnt[0], 32'd0);
    chk("post-rst refill", 32'(rf_cnt[0] - rf0), 32'd1);
    chk("post-rst rf_addr", 32'(rf_addr[0]), 32'h008);

    for (int i = 0; i < 8; i++) begin
      a = i[0] ? 10'h088 : 10'h008;
      access(1, 1'b0, a, '0, rd, lat);
      chk($sformatf("dm ld%0d %h", i, a), rd, mem[1][a]);
    end
    chk("dm miss_cnt", miss_cnt[1], 32'd8);
    chk("dm hit_cnt", hit_cnt[1], 32'd0);
    chk("dm wb bursts", 32'(wb_cnt[1]), 32'd0);
    chk("dm rf bursts", 32'(rf_cnt[1]), 32'd8);
    chk("burst stability dut1", 32'(stab_err[1]), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
